// File: rtl/press_pkg.sv
// press_pkg: shared types for the press classifier.
//   state_t - classifier FSM states
//   ev_t    - event codes produced by the next-state logic
//   timer_width() - interval timer width sized so it can reach the longer timeout
package press_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    WAIT_GAP  = 3'd3,
    WAIT_REL  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_SHORT  = 2'd1,
    EV_LONG   = 2'd2,
    EV_DOUBLE = 2'd3
  } ev_t;

  function automatic int timer_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/press_classifier_interval_timer.sv
// interval_timer: saturating up-counter with synchronous clear.
//   i_clk    clock
//   i_reset  synchronous active-high reset
//   i_clr    clear count to 0 (wins over i_en)
//   i_en     count up by one per edge, holding at all-ones
//   o_count  current count
module interval_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr)
      r_count <= '0;
    else if (i_en && (r_count != '1))
      r_count <= r_count + 1'b1;   // saturate so a stuck state never wraps into a false match
  end

  assign o_count = r_count;

endmodule

// File: rtl/press_classifier.sv
// press_classifier: turns debounced button level/edges into gesture events.
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_debounced       debounced level, 1 = pressed
//   i_p_edge/i_n_edge one-cycle pulses on debounced rising/falling edges
//   o_short_press     pulse: single short press confirmed (after the gap timeout)
//   o_long_press      pulse: press held LONG_CYCLES
//   o_double_press    pulse: second press arrived within the gap
//   o_hold            level: long press still held
//   o_evt_cnt         wrapping count of classified events
module press_classifier
  import press_pkg::*;
#(
  parameter int LONG_CYCLES       = 50_000_000,
  parameter int DOUBLE_GAP_CYCLES = 25_000_000,
  parameter int EVT_W             = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_debounced,
  input  logic             i_p_edge,
  input  logic             i_n_edge,
  output logic             o_short_press,
  output logic             o_long_press,
  output logic             o_double_press,
  output logic             o_hold,
  output logic [EVT_W-1:0] o_evt_cnt
);

  localparam int TW = timer_width(LONG_CYCLES, DOUBLE_GAP_CYCLES);
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(DOUBLE_GAP_CYCLES - 1);

  state_t          r_state, w_next;
  ev_t             w_ev;
  logic [TW-1:0]   w_cnt;
  logic            w_clr, w_en;
  logic            w_rise;
  logic            r_short, r_long, r_double, r_hold;
  logic [EVT_W-1:0] r_evt_cnt;

  // A simultaneous p_edge/n_edge is treated as a release only.
  assign w_rise = i_p_edge && !i_n_edge;

  // Timer restarts on every state change and only runs in the timed states.
  assign w_clr = (w_next != r_state);
  assign w_en  = (r_state == PRESSED) || (r_state == WAIT_GAP);

  interval_timer #(.W(TW)) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .o_count (w_cnt)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_ev   = EV_NONE;
    case (r_state)
      IDLE:      if (w_rise) w_next = PRESSED;
      PRESSED: begin
        // release takes priority over the long timeout on the same edge
        if (i_n_edge) w_next = WAIT_GAP;
        else if ((w_cnt == LONG_LAST) && i_debounced) begin
          w_next = LONG_HELD;
          w_ev   = EV_LONG;
        end
      end
      LONG_HELD: if (i_n_edge) w_next = IDLE;
      WAIT_GAP: begin
        // re-press takes priority over the gap timeout on the same edge
        if (w_rise) begin
          w_next = WAIT_REL;
          w_ev   = EV_DOUBLE;
        end else if (w_cnt == GAP_LAST) begin
          w_next = IDLE;
          w_ev   = EV_SHORT;
        end
      end
      WAIT_REL:  if (i_n_edge) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_double  <= 1'b0;
      r_hold    <= 1'b0;
      r_evt_cnt <= '0;
    end else begin
      r_short  <= (w_ev == EV_SHORT);
      r_long   <= (w_ev == EV_LONG);
      r_double <= (w_ev == EV_DOUBLE);
      r_hold   <= (w_next == LONG_HELD);
      if (w_ev != EV_NONE) r_evt_cnt <= r_evt_cnt + 1'b1;
    end
  end

  assign o_short_press  = r_short;
  assign o_long_press   = r_long;
  assign o_double_press = r_double;
  assign o_hold         = r_hold;
  assign o_evt_cnt      = r_evt_cnt;

endmodule

// File: tb/tb_press_classifier.sv
module tb_press_classifier;

  localparam int LONG  = 20;
  localparam int GAP   = 10;
  localparam int EVT_W = 2;

  logic clk = 1'b0;
  logic i_reset, i_debounced, i_p_edge, i_n_edge;
  logic o_short_press, o_long_press, o_double_press, o_hold;
  logic [EVT_W-1:0] o_evt_cnt;

  press_classifier #(.LONG_CYCLES(LONG), .DOUBLE_GAP_CYCLES(GAP), .EVT_W(EVT_W)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_debounced(i_debounced),
    .i_p_edge(i_p_edge), .i_n_edge(i_n_edge),
    .o_short_press(o_short_press), .o_long_press(o_long_press),
    .o_double_press(o_double_press), .o_hold(o_hold), .o_evt_cnt(o_evt_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  // ---------------- behavioural model (absolute-time gesture rules) ----------------
  bit pressing, long_on, gap_open, second_down;
  int t_p, t_n;
  bit e_s, e_l, e_d;
  int e_cnt;

  always @(posedge clk) begin
    bit pe, ne;
    cyc++;
    e_s = 0; e_l = 0; e_d = 0;
    if (i_reset) begin
      pressing = 0; long_on = 0; gap_open = 0; second_down = 0; e_cnt = 0;
    end else begin
      ne = i_n_edge;
      pe = i_p_edge && !i_n_edge;
      if (pressing) begin
        if (ne) begin pressing = 0; gap_open = 1; t_n = cyc; end
        else if ((cyc - t_p == LONG) && i_debounced) begin pressing = 0; long_on = 1; e_l = 1; end
      end else if (long_on) begin
        if (ne) long_on = 0;
      end else if (gap_open) begin
        if (pe) begin gap_open = 0; second_down = 1; e_d = 1; end
        else if (cyc - t_n == GAP) begin gap_open = 0; e_s = 1; end
      end else if (second_down) begin
        if (ne) second_down = 0;
      end else if (pe) begin
        pressing = 1; t_p = cyc;
      end
      if (e_s || e_l || e_d) e_cnt = (e_cnt + 1) % (1 << EVT_W);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare + pulse timestamps ----------------
  int last_short = -1, last_long = -1, last_double = -1;

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("short_press", int'(o_short_press), int'(e_s));
      chk("long_press", int'(o_long_press), int'(e_l));
      chk("double_press", int'(o_double_press), int'(e_d));
      chk("hold", int'(o_hold), int'(long_on));
      chk("evt_cnt", int'(o_evt_cnt), e_cnt);
    end
    if (o_short_press === 1'b1)  last_short  = cyc;
    if (o_long_press === 1'b1)   last_long   = cyc;
    if (o_double_press === 1'b1) last_double = cyc;
  end

  // ---------------- stimulus helpers ----------------
  // drive values, then return #1 after the edge that samples them (cyc == that edge)
  task automatic drive(input bit d, input bit pe, input bit ne);
    i_debounced = d; i_p_edge = pe; i_n_edge = ne;
    @(posedge clk); #1;
  endtask

  task automatic press(input int n, output int t);
    drive(1, 1, 0); t = cyc;
    repeat (n - 1) drive(1, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0);
  endtask

  task automatic release_btn(input int n, output int t);
    drive(0, 0, 1); t = cyc;
    idle(n - 1);
  endtask

  task automatic clear_marks();
    last_short = -1; last_long = -1; last_double = -1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    drive(0, 0, 0);
    drive(0, 0, 0);
    i_reset = 1'b0;
    clear_marks();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_short"}, int'(o_short_press), 0);
    chk({tag, "_long"}, int'(o_long_press), 0);
    chk({tag, "_double"}, int'(o_double_press), 0);
    chk({tag, "_hold"}, int'(o_hold), 0);
    chk({tag, "_cnt"}, int'(o_evt_cnt), 0);
  endtask

  initial begin
    int tp, tn, tp2, t;
    int wrap_exp [5] = '{1, 2, 3, 0, 1};
    i_reset = 1'b1; i_debounced = 0; i_p_edge = 0; i_n_edge = 0;
    @(posedge clk); #1;
    do_reset();
    chk_all_zero("reset");

    // short press: 5 high, release, idle
    press(5, tp); release_btn(16, tn);
    chk("short_lat", last_short, tn + GAP);
    chk("short_cnt", int'(o_evt_cnt), 1);
    chk("short_nolong", last_long, -1);

    // long press with hold
    do_reset();
    press(30, tp);
    chk("long_lat", last_long, tp + LONG);
    chk("hold_on", int'(o_hold), 1);
    release_btn(1, tn);
    chk("hold_off", int'(o_hold), 0);
    idle(15);
    chk("long_noshort", last_short, -1);

    // double press, re-press 4 cycles after release
    do_reset();
    press(5, tp); release_btn(4, tn); press(3, tp2);
    chk("dbl_gap", tp2 - tn, 4);
    chk("dbl_lat", last_double, tp2);
    release_btn(15, tn);
    chk("dbl_noshort", last_short, -1);

    // re-press exactly on the gap timeout edge
    do_reset();
    press(5, tp); release_btn(GAP, tn); press(4, tp2);
    chk("edge_dbl", last_double, tn + GAP);
    release_btn(15, t);
    chk("edge_noshort", last_short, -1);

    // release exactly on the long timeout edge
    clear_marks();
    press(LONG, tp); release_btn(12, tn);
    chk("rel_edge_tn", tn - tp, LONG);
    chk("rel_edge_short", last_short, tn + GAP);
    chk("rel_edge_nolong", last_long, -1);

    // reset mid-PRESSED, still held after reset
    do_reset();
    press(5, tp); release_btn(12, tn);
    press(5, tp);
    i_reset = 1'b1; drive(1, 0, 0); i_reset = 1'b0;
    chk_all_zero("rstp");
    clear_marks();
    repeat (30) drive(1, 0, 0);
    release_btn(15, tn);
    chk("rstp_noshort", last_short, -1);
    chk("rstp_nolong", last_long, -1);

    // reset mid-WAIT_GAP
    press(5, tp); release_btn(3, tn);
    i_reset = 1'b1; drive(0, 0, 0); i_reset = 1'b0;
    chk_all_zero("rstg");
    clear_marks();
    idle(20);
    chk("rstg_noshort", last_short, -1);

    // evt_cnt wrap over five shorts
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press(3, tp); release_btn(12, tn);
      chk($sformatf("wrap%0d", i), int'(o_evt_cnt), wrap_exp[i]);
    end

    // p_edge and n_edge together behave as a release
    do_reset();
    press(5, tp);
    drive(0, 1, 1); t = cyc;
    idle(11);
    chk("both_short", last_short, t + GAP);
    chk("both_nodbl", last_double, -1);

    // randomized gestures, checked every cycle against the model
    for (int g = 0; g < 150; g++) begin
      if ($urandom_range(0, 19) == 0) begin
        i_reset = 1'b1; drive(i_debounced, 0, 0); i_reset = 1'b0;
      end
      press($urandom_range(1, 30), tp);
      if ($urandom_range(0, 9) == 0) begin
        drive(0, 1, 1); idle($urandom_range(0, 13));
      end else begin
        release_btn($urandom_range(1, 14), tn);
      end
      if ($urandom_range(0, 2) == 0) begin
        press($urandom_range(1, 25), tp2);
        release_btn($urandom_range(1, 14), tn);
      end
    end
    idle(15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
